// File: rtl/seven_seg_scan_n.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_n
//
// Time-multiplexed driver for NDIGITS common-anode seven-segment digits.
// Each digit owns a slot of DIV clock cycles. The first cycle of every slot
// is a dark gap so the previous digit's segments never ghost onto the next
// anode. Display inputs are captured into shadow registers only at frame
// boundaries, so a frame is always drawn from one consistent snapshot.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   data        packed nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp          per-digit decimal point request, active-high
//   blank       per-digit force-off, active-high
//   lzb         leading-zero blanking enable
//   segs_n      active-low segments, segs_n[6]=g ... segs_n[0]=a
//   dp_n        active-low decimal point
//   an_n        active-low anode enables (one-hot-low or all ones)
//   frame_tick  one-cycle pulse at the end of each full scan frame
//
// All outputs are registered: they reflect the scan position and shadow
// contents of the previous cycle (one cycle of latency).
// ----------------------------------------------------------------------------
module seven_seg_scan_n #(
    parameter int NDIGITS = 8,
    parameter int DIV     = 100000,
    parameter bit HEX     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NDIGITS-1:0]   data,
    input  logic [NDIGITS-1:0]     dp,
    input  logic [NDIGITS-1:0]     blank,
    input  logic                   lzb,
    output logic [6:0]             segs_n,
    output logic                   dp_n,
    output logic [NDIGITS-1:0]     an_n,
    output logic                   frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam int IW = ($clog2(NDIGITS) > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0]          cnt_q,        cnt_d;
    logic [IW-1:0]          idx_q,        idx_d;
    logic                   load_q,       load_d;
    logic [4*NDIGITS-1:0]   sh_data_q,    sh_data_d;
    logic [NDIGITS-1:0]     sh_dp_q,      sh_dp_d;
    logic [NDIGITS-1:0]     sh_blank_q,   sh_blank_d;
    logic                   sh_lzb_q,     sh_lzb_d;
    logic [6:0]             segs_n_q,     segs_n_d;
    logic                   dp_n_q,       dp_n_d;
    logic [NDIGITS-1:0]     an_n_q,       an_n_d;
    logic                   frame_tick_q, frame_tick_d;

    // ------------------------------------------------------------------
    // Per-digit views of the shadow data
    // ------------------------------------------------------------------
    logic [3:0]         nib [NDIGITS];
    logic [NDIGITS-1:0] an_sel_n;   // anode pattern for the current digit

    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
        assign nib[gi]      = sh_data_q[4*gi +: 4];
        assign an_sel_n[gi] = (idx_q != IW'(gi));
    end

    // ------------------------------------------------------------------
    // Nibble to active-low gfedcba pattern
    // ------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = HEX ? 7'b0001000 : 7'h7F;
            4'hB:    s = HEX ? 7'b0000011 : 7'h7F;
            4'hC:    s = HEX ? 7'b1000110 : 7'h7F;
            4'hD:    s = HEX ? 7'b0100001 : 7'h7F;
            4'hE:    s = HEX ? 7'b0000110 : 7'h7F;
            default: s = HEX ? 7'b0001110 : 7'h7F;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    logic tick;
    logic frame_end;
    logic capture;
    logic upper_zero;   // current digit and every digit to its left are 0
    logic digit_off;

    always_comb begin
        tick      = (cnt_q == CNT_LAST);
        frame_end = tick && (idx_q == IDX_LAST);

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Snapshot at the first cycle out of reset and on each frame wrap,
        // so digit 0 of every frame already sees the new values.
        capture    = load_q || frame_end;
        load_d     = 1'b0;
        sh_data_d  = capture ? data  : sh_data_q;
        sh_dp_d    = capture ? dp    : sh_dp_q;
        sh_blank_d = capture ? blank : sh_blank_q;
        sh_lzb_d   = capture ? lzb   : sh_lzb_q;

        upper_zero = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((i >= int'(idx_q)) && (nib[i] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end

        // cnt==0 is the anti-ghost gap at the start of every slot.
        digit_off = (cnt_q == '0)
                 || sh_blank_q[idx_q]
                 || (sh_lzb_q && (idx_q != '0) && upper_zero);

        segs_n_d = 7'h7F;
        dp_n_d   = 1'b1;
        an_n_d   = '1;
        if (!digit_off) begin
            an_n_d   = an_sel_n;
            segs_n_d = decode(nib[idx_q]);
            dp_n_d   = ~sh_dp_q[idx_q];
        end

        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            load_q       <= 1'b1;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            sh_lzb_q     <= 1'b0;
            segs_n_q     <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            load_q       <= load_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            sh_lzb_q     <= sh_lzb_d;
            segs_n_q     <= segs_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign segs_n     = segs_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan_n
//
// Drives a HEX=1 and a HEX=0 instance (NDIGITS=4, DIV=4) from the same
// inputs and compares both against a reference that treats the scan as one
// free-running cycle count since reset release: slot = (t mod 16) / 4,
// position in slot = (t mod 16) % 4. Directed scenarios come first, then a
// randomized run with occasional resets.
// ----------------------------------------------------------------------------
module tb_seven_seg_scan_n;

    localparam int N = 4;
    localparam int D = 4;
    localparam int F = N * D;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzb;

    logic [6:0]  segs_h, segs_x;
    logic        dp_h,   dp_x;
    logic [3:0]  an_h,   an_x;
    logic        ft_h,   ft_x;

    always #5 clk = ~clk;

    seven_seg_scan_n #(.NDIGITS(N), .DIV(D), .HEX(1'b1)) dut_hex (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .lzb        (lzb),
        .segs_n     (segs_h),
        .dp_n       (dp_h),
        .an_n       (an_h),
        .frame_tick (ft_h)
    );

    seven_seg_scan_n #(.NDIGITS(N), .DIV(D), .HEX(1'b0)) dut_dec (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .lzb        (lzb),
        .segs_n     (segs_x),
        .dp_n       (dp_x),
        .an_n       (an_x),
        .frame_tick (ft_x)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: cycles since reset release, plus the snapshot.
    int          t = 0;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic        m_lzb;
    logic [6:0]  seg_tab [16];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // One clock: predict what the edge produces, advance, then compare.
    task automatic step();
        logic [6:0] e_segs_h, e_segs_x;
        logic       e_dp, e_ft;
        logic [3:0] e_an, nibv;
        int         p, slot, c;
        bit         off;
        e_segs_h = 7'h7F;
        e_segs_x = 7'h7F;
        e_dp     = 1'b1;
        e_an     = 4'hF;
        e_ft     = 1'b0;
        if (rst) begin
            t       = 0;
            m_data  = '0;
            m_dp    = '0;
            m_blank = '0;
            m_lzb   = 1'b0;
        end else begin
            p    = t % F;
            slot = p / D;
            c    = p % D;
            e_ft = (p == F - 1);
            off  = (c == 0) || m_blank[slot]
                || (m_lzb && slot > 0 && (m_data >> (4 * slot)) == 0);
            nibv = m_data[4*slot +: 4];
            if (!off) begin
                e_an     = ~(4'b0001 << slot);
                e_segs_h = seg_tab[nibv];
                e_segs_x = (nibv > 9) ? 7'h7F : seg_tab[nibv];
                e_dp     = ~m_dp[slot];
            end
            if (t == 0 || p == F - 1) begin
                m_data  = data;
                m_dp    = dp;
                m_blank = blank;
                m_lzb   = lzb;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check("segs_hex", {1'b0, segs_h}, {1'b0, e_segs_h});
        check("segs_dec", {1'b0, segs_x}, {1'b0, e_segs_x});
        check("an_hex",   {4'b0, an_h},   {4'b0, e_an});
        check("an_dec",   {4'b0, an_x},   {4'b0, e_an});
        check("dp_hex",   {7'b0, dp_h},   {7'b0, e_dp});
        check("dp_dec",   {7'b0, dp_x},   {7'b0, e_dp});
        check("ft_hex",   {7'b0, ft_h},   {7'b0, e_ft});
        check("ft_dec",   {7'b0, ft_x},   {7'b0, e_ft});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        // Held reset, then basic scan of 4321 over several frames.
        rst = 1'b1; data = 16'h4321; dp = '0; blank = '0; lzb = 1'b0;
        run(3);
        rst = 1'b0;
        run(40);

        // Hex letters (dark on the HEX=0 instance), with decimal points.
        data = 16'hFEDC; dp = 4'b1010;
        run(36);

        // Leading-zero blanking suppresses digit 2 including its dp.
        data = 16'h0050; dp = 4'b0100; lzb = 1'b1;
        run(36);

        // All zero: only digit 0; then blanking digit 0 leaves all dark.
        data = 16'h0000; dp = '0;
        run(32);
        blank = 4'b0001;
        run(32);

        // Mid-frame data change stays invisible until the next frame.
        blank = '0; lzb = 1'b0; data = 16'h1111;
        for (int k = 0; k < 2 * F && (t % F) != 5; k++) step();
        data = 16'h2222;
        run(36);

        // One-cycle reset at idx=2, cnt=2.
        for (int k = 0; k < 2 * F && (t % F) != 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(24);

        // Randomized inputs with occasional resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                data  = 16'($urandom);
                if ($urandom_range(0, 1) == 1) data = data & 16'h00FF;
                dp    = 4'($urandom);
                blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                lzb   = 1'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        run(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
